timer_ctrl: RTL
===============

// Module: timer_ctrl
// PURPOSE
//  APB-style register front end and sequencer for the 8-bit timer counter.
//  - Holds TDR/TCR/TSR, generates the one-cycle load pulse and write-1-to-clear pulses.
//  - Generates the prescaled clk_ena strobe (div 2/4/8/16).
//  - Sits between the bus and the counter; the counter is driven only by this block.
// PARAMETERS
//  ADDR_W   8   APB address width; only paddr[2:0] are decoded, upper bits must be 0
//  DATA_W   8   register/data width; fixed 8, other values unsupported
// PORTS
//  clk            in   1  system clock, all logic on posedge
//  rst            in   1  asynchronous reset, active-high
//  psel           in   1  APB select
//  penable        in   1  APB access phase
//  pwrite         in   1  1=write, 0=read
//  paddr          in   8  register address
//  pwdata         in   8  write data
//  prdata         out  8  read data, valid when psel&penable&pready
//  pready         out  1  transfer complete
//  pslverr        out  1  error response, valid with pready
//  clk_ena        out  1  one-cycle count strobe to counter
//  start_counter  out  8  load value (= TDR)
//  load           out  1  one-cycle load pulse to counter
//  up_down        out  1  1=up, 0=down (= TCR[5])
//  enable         out  1  count enable to counter
//  clr_overflow   out  1  one-cycle clear pulse
//  clr_underflow  out  1  one-cycle clear pulse
//  tcnt           in   8  counter value for readback
//  overflow       in   1  counter sticky overflow flag
//  underflow      in   1  counter sticky underflow flag
// BEHAVIOUR
//  Map: 0x0 TDR rw; 0x1 TCR rw {load[7],0,up_down[5],enable[4],00,cks[1:0]};
//   0x2 TSR {000000,udf[1],ovf[0]} read=live flags, write 1 clears; 0x3 TCNT ro.
//  Reset: all registers 0, outputs 0, pready=0, prdata=0, FSM=IDLE, divider=0.
//  APB: access completes in ACCESS phase (psel&penable) with pready=1, zero wait,
//   except a TCR write while FSM!=IDLE gets pready=0 until FSM returns to IDLE.
//  Write takes effect on the completing edge; prdata registered in ACCESS phase.
//  pslverr=1 (write discarded, prdata=0) for addr>=0x4 (>=0x5 with IRQ), or write to 0x3.
//  TSR write: pwdata[0]=1 -> clr_overflow=1 next cycle for 1 clk; bit1 -> clr_underflow.
//  Sequencer FSM: IDLE -> LOAD on TCR write with pwdata[7]=1;
//   LOAD (1 clk): load=1, enable=0, start_counter=TDR; -> SETTLE;
//   SETTLE (1 clk): load=0, enable=0; -> IDLE. TCR[7] self-clears, reads 0.
//   IDLE: enable=TCR[4]. Write with load=1 and enable=1: counting resumes after SETTLE.
//  Prescaler: 4-bit free-running div counter; sel bit = div[cks];
//   clk_ena=1 for one clk on 0->1 of sel bit (period 2<<cks clks).
//   TCR write changing cks clears div to 0; clk_ena suppressed that cycle.
//  Simultaneous TSR W1C and counter setting flag: clear pulse still issued; counter
//   priority decides (flag set wins); block does not mask.
//  rst mid-operation: FSM to IDLE, pulses drop same instant (async), registers 0.
// CONFIGURATION
//  TIMER_CTRL_IRQ_EN defined: adds port irq out 1 and TIER at 0x4 {ovie[0],udie[1]};
//   irq = registered (ovf&ovie)|(udf&udie), 1 clk after flag; reset 0.
//  Undefined: no irq port, no TIER, addr 0x4 -> pslverr.
// TESTING
//  1 Reset 5 clk, release -> all outputs 0, TCR/TDR/TSR read 0x00, pslverr=0.
//  2 Write TDR=0x80, TCR=0x90 -> load high exactly 1 clk, start_counter=0x80,
//    enable=0 two clks then 1; TCR readback 0x10.
//  3 TCR cks=0..3, enable=1 -> clk_ena period 2,4,8,16 clks, each pulse 1 clk wide.
//  4 TDR=0x00, TCR=0x80 down -> underflow=1; TSR reads 0x02; write TSR=0x02 ->
//    clr_underflow 1 clk pulse, TSR reads 0x00.
//  5 TCR write during LOAD -> pready=0 for 1-2 clks then 1; write addr 0x7/0x3 -> pslverr=1.
//  6 IRQ_EN: TIER=0x01, force overflow -> irq=1 one clk later; TSR W1C -> irq=0.

Source files
------------

// File: rtl/timer_ctrl.sv
// timer_ctrl: APB register front end, load sequencer and clk_ena prescaler for the 8-bit timer counter.
// Optional feature macro TIMER_CTRL_IRQ_EN adds the TIER register at 0x4 and the irq output.
module timer_ctrl #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [ADDR_W-1:0] paddr,
   input  logic [DATA_W-1:0] pwdata,
   output logic [DATA_W-1:0] prdata,
   output logic              pready,
   output logic              pslverr,
   output logic              clk_ena,
   output logic [DATA_W-1:0] start_counter,
   output logic              load,
   output logic              up_down,
   output logic              enable,
   output logic              clr_overflow,
   output logic              clr_underflow,
   input  logic [DATA_W-1:0] tcnt,
   input  logic              overflow,
   input  logic              underflow
`ifdef TIMER_CTRL_IRQ_EN
   ,
   output logic              irq
`endif
);

   localparam logic [ADDR_W-1:0] A_TDR  = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] A_TCR  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] A_TSR  = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] A_TCNT = ADDR_W'(3);
`ifdef TIMER_CTRL_IRQ_EN
   localparam logic [ADDR_W-1:0] A_TIER = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] A_LIM  = ADDR_W'(5);
`else
   localparam logic [ADDR_W-1:0] A_LIM  = ADDR_W'(4);
`endif

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SETTLE} state_t;

   state_t            state;
   logic [DATA_W-1:0] tdr;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        cks;
   logic              tcr_ud;
   logic              tcr_en;
   logic [3:0]        div;
   logic [3:0]        div_nxt;
   logic              access;
   logic              stall;
   logic              addr_err;
   logic              wr_fire;
   logic              tcr_wr;
   logic              cks_chg;
`ifdef TIMER_CTRL_IRQ_EN
   logic [1:0]        tier;
`endif

   // A TCR write is held off while a load sequence is in flight so the sequence sees stable fields
   assign access   = psel & penable;
   assign stall    = access & pwrite & (paddr == A_TCR) & (state != ST_IDLE);
   assign pready   = access & ~stall;
   assign addr_err = (paddr >= A_LIM) | (pwrite & (paddr == A_TCNT));
   assign pslverr  = pready & addr_err;
   assign wr_fire  = pready & pwrite & ~addr_err;
   assign tcr_wr   = wr_fire & (paddr == A_TCR);
   assign cks_chg  = tcr_wr & (pwdata[1:0] != cks);

   assign start_counter = tdr;
   assign up_down       = tcr_ud;
   assign div_nxt       = div + 4'd1;

   always_comb begin
      rdata = '0;
      case (paddr)
         A_TDR:   rdata = tdr;
         A_TCR:   rdata = DATA_W'({2'b00, tcr_ud, tcr_en, 2'b00, cks});
         A_TSR:   rdata = DATA_W'({underflow, overflow});
         A_TCNT:  rdata = tcnt;
`ifdef TIMER_CTRL_IRQ_EN
         A_TIER:  rdata = DATA_W'(tier);
`endif
         default: rdata = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tdr           <= '0;
         cks           <= '0;
         tcr_ud        <= 1'b0;
         tcr_en        <= 1'b0;
         clr_overflow  <= 1'b0;
         clr_underflow <= 1'b0;
         prdata        <= '0;
      end else begin
         clr_overflow  <= wr_fire & (paddr == A_TSR) & pwdata[0];
         clr_underflow <= wr_fire & (paddr == A_TSR) & pwdata[1];
         if (wr_fire && (paddr == A_TDR))
            tdr <= pwdata;
         if (tcr_wr) begin
            tcr_ud <= pwdata[5];
            tcr_en <= pwdata[4];
            cks    <= pwdata[1:0];
         end
         if (psel && !pwrite)
            prdata <= addr_err ? '0 : rdata;
      end
   end

   // Load sequencer: LOAD pulses load with enable held off, SETTLE gives the counter one quiet cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         load   <= 1'b0;
         enable <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (tcr_wr && pwdata[7]) begin
                  state  <= ST_LOAD;
                  load   <= 1'b1;
                  enable <= 1'b0;
               end else begin
                  enable <= tcr_wr ? pwdata[4] : tcr_en;
               end
            end
            ST_LOAD: begin
               state  <= ST_SETTLE;
               load   <= 1'b0;
               enable <= 1'b0;
            end
            ST_SETTLE: begin
               state  <= ST_IDLE;
               enable <= tcr_en;
            end
            default: begin
               state  <= ST_IDLE;
               load   <= 1'b0;
               enable <= 1'b0;
            end
         endcase
      end
   end

   // Strobe on the rising edge of div[cks]; a new rate restarts the divider without a stray pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div     <= '0;
         clk_ena <= 1'b0;
      end else if (cks_chg) begin
         div     <= '0;
         clk_ena <= 1'b0;
      end else begin
         div     <= div_nxt;
         clk_ena <= div_nxt[cks] & ~div[cks];
      end
   end

`ifdef TIMER_CTRL_IRQ_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tier <= '0;
         irq  <= 1'b0;
      end else begin
         if (wr_fire && (paddr == A_TIER))
            tier <= pwdata[1:0];
         irq <= (overflow & tier[0]) | (underflow & tier[1]);
      end
   end
`endif

endmodule
